// File: rtl/int_seq.sv
// Interrupt entry sequencer: drains the pipeline, stacks the return PC and flags,
// vectors to the ISR and tracks service until RTI reaches EX.
module int_seq #(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] VECTOR_ADDR  = DATA_W'(8'h01),
    parameter int                DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic              bt,
    input  logic              hu_stall,
    input  logic              rti_ex,
    input  logic [DATA_W-1:0] pc_ret,
    input  logic [3:0]        flags_in,
    input  logic              push_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              flush,
    output logic              push_req,
    output logic [DATA_W-1:0] push_data,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_vec,
    output logic              int_ack,
    output logic              int_active
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_PC  = 3'd2,
        PUSH_FLG = 3'd3,
        VECTOR   = 3'd4,
        ISR      = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [2:0]          cnt_reg;
    logic [DATA_W-1:0]   ret_pc_reg;
    logic [3:0]          flg_reg;

    logic                pc_en_reg;
    logic                if_id_en_reg;
    logic                flush_reg;
    logic                push_req_reg;
    logic [DATA_W-1:0]   push_data_reg;
    logic                pc_load_reg;
    logic                int_ack_reg;
    logic                int_active_reg;

    // Entry is only accepted when the front end is moving, so the captured
    // pc_ret really is the oldest uncommitted instruction.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (irq && !bt && !hu_stall) state_next = DRAIN;
            DRAIN:    if (cnt_reg == 3'd0)         state_next = PUSH_PC;
            PUSH_PC:  if (push_ack)                state_next = PUSH_FLG;
            PUSH_FLG: if (push_ack)                state_next = VECTOR;
            VECTOR:                                state_next = ISR;
            ISR:      if (rti_ex)                  state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they equal a pure
    // decode of the current state with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            ret_pc_reg     <= '0;
            flg_reg        <= 4'd0;
            pc_en_reg      <= 1'b1;
            if_id_en_reg   <= 1'b1;
            flush_reg      <= 1'b0;
            push_req_reg   <= 1'b0;
            push_data_reg  <= '0;
            pc_load_reg    <= 1'b0;
            int_ack_reg    <= 1'b0;
            int_active_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && state_next == DRAIN) begin
                ret_pc_reg <= pc_ret;
                flg_reg    <= flags_in;
                cnt_reg    <= 3'(DRAIN_CYCLES - 1);
            end else if (state_reg == DRAIN && cnt_reg != 3'd0) begin
                cnt_reg <= cnt_reg - 3'd1;
            end

            pc_en_reg      <= (state_next inside {IDLE, VECTOR, ISR});
            if_id_en_reg   <= (state_next inside {IDLE, VECTOR, ISR});
            flush_reg      <= (state_next inside {DRAIN, PUSH_PC, PUSH_FLG, VECTOR});
            push_req_reg   <= (state_next inside {PUSH_PC, PUSH_FLG});
            pc_load_reg    <= (state_next == VECTOR);
            int_ack_reg    <= (state_next == VECTOR);
            int_active_reg <= (state_next == ISR);

            case (state_next)
                PUSH_PC:  push_data_reg <= ret_pc_reg;
                PUSH_FLG: push_data_reg <= DATA_W'(flg_reg);
                default:  push_data_reg <= '0;
            endcase
        end
    end

    assign pc_en      = pc_en_reg;
    assign if_id_en   = if_id_en_reg;
    assign flush      = flush_reg;
    assign push_req   = push_req_reg;
    assign push_data  = push_data_reg;
    assign pc_load    = pc_load_reg;
    assign pc_vec     = VECTOR_ADDR;
    assign int_ack    = int_ack_reg;
    assign int_active = int_active_reg;

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: stimulus queues expected pushes/vector entries,
// a negedge monitor pops and compares them; cycle-level state checks run inline.
module tb_int_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq, bt, hu_stall, rti_ex, push_ack;
    logic [7:0] pc_ret;
    logic [3:0] flags_in;
    logic       pc_en, if_id_en, flush, push_req, pc_load, int_ack, int_active;
    logic [7:0] push_data, pc_vec;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_push[$];
    logic [11:0] exp_vec[$];

    // {pc_en, if_id_en, flush, push_req, pc_load, int_ack, int_active}
    localparam logic [6:0] O_IDLE  = 7'b1100000;
    localparam logic [6:0] O_DRAIN = 7'b0010000;
    localparam logic [6:0] O_PUSH  = 7'b0011000;
    localparam logic [6:0] O_VEC   = 7'b1110110;
    localparam logic [6:0] O_ISR   = 7'b1100001;
    localparam logic [11:0] VEC_EXP = {8'h01, 4'b1111};

    int_seq #(.DATA_W(8), .VECTOR_ADDR(8'h01), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .irq(irq), .bt(bt), .hu_stall(hu_stall),
        .rti_ex(rti_ex), .pc_ret(pc_ret), .flags_in(flags_in), .push_ack(push_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .flush(flush), .push_req(push_req),
        .push_data(push_data), .pc_load(pc_load), .pc_vec(pc_vec),
        .int_ack(int_ack), .int_active(int_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%h t=%0t", name, act, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic [6:0] exp);
        check(name, {25'd0, pc_en, if_id_en, flush, push_req, pc_load, int_ack, int_active},
              {25'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a push completes when push_req and push_ack are both high at the edge.
    always @(negedge clk) begin
        if (!rst && push_req && push_ack) begin
            if (exp_push.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_push actual=%h required=none t=%0t", push_data, $time);
            end else begin
                check("push_data", {24'd0, push_data}, {24'd0, exp_push.pop_front()});
            end
        end
        if (!rst && pc_load) begin
            if (exp_vec.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_vector actual=%h required=none t=%0t", pc_vec, $time);
            end else begin
                check("vector", {20'd0, pc_vec, int_ack, flush, pc_en, if_id_en},
                      {20'd0, exp_vec.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; irq = 1'b0; bt = 1'b0; hu_stall = 1'b0; rti_ex = 1'b0;
        push_ack = 1'b1; pc_ret = 8'h00; flags_in = 4'h0;
        #3;
        check_outs("reset_outs", O_IDLE);
        check("reset_push_data", {24'd0, push_data}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_outs("idle_no_irq", O_IDLE);

        // Basic entry
        irq = 1'b1; pc_ret = 8'h3C; flags_in = 4'b1010;
        exp_push.push_back(8'h3C); exp_push.push_back(8'h0A); exp_vec.push_back(VEC_EXP);
        step(); check_outs("basic_drain1", O_DRAIN);
        pc_ret = 8'h77; flags_in = 4'h0;
        step(); check_outs("basic_drain2", O_DRAIN);
        step(); check_outs("basic_push_pc", O_PUSH);
        step(); check_outs("basic_push_flg", O_PUSH);
        step(); check_outs("basic_vector", O_VEC);
        step(); check_outs("basic_isr", O_ISR);
        step(); check_outs("isr_no_nesting", O_ISR);

        // Return with irq still high, re-entry under backpressure
        rti_ex = 1'b1; pc_ret = 8'h3C; flags_in = 4'b0001; push_ack = 1'b0;
        step(); check_outs("rti_to_idle", O_IDLE);
        rti_ex = 1'b0;
        exp_push.push_back(8'h3C);
        step(); check_outs("reentry_drain1", O_DRAIN);
        rti_ex = 1'b1;
        step(); check_outs("rti_in_drain_ignored", O_DRAIN);
        rti_ex = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs("backpressure_hold", O_PUSH);
            check("backpressure_data", {24'd0, push_data}, 32'h3C);
        end
        push_ack = 1'b1;
        step(); check_outs("ack_to_push_flg", O_PUSH);
        check("push_flg_data", {24'd0, push_data}, 32'h01);

        // Asynchronous reset between edges while in PUSH_FLG
        #1 rst = 1'b1; irq = 1'b0;
        #1;
        check_outs("async_reset_outs", O_IDLE);
        check("async_reset_data", {24'd0, push_data}, 32'd0);
        #1 rst = 1'b0;
        step(); step();
        check_outs("post_reset_idle", O_IDLE);

        // Deferral by bt then hu_stall
        irq = 1'b1; bt = 1'b1; pc_ret = 8'h11; flags_in = 4'hF;
        step(); check_outs("defer_bt1", O_IDLE);
        step(); check_outs("defer_bt2", O_IDLE);
        bt = 1'b0; hu_stall = 1'b1;
        step(); check_outs("defer_stall", O_IDLE);
        hu_stall = 1'b0; pc_ret = 8'h22; flags_in = 4'b0110;
        exp_push.push_back(8'h22); exp_push.push_back(8'h06); exp_vec.push_back(VEC_EXP);
        step(); check_outs("defer_release_drain", O_DRAIN);
        pc_ret = 8'h99;
        step(); check_outs("defer_drain2", O_DRAIN);
        step(); check_outs("defer_push_pc", O_PUSH);
        step(); check_outs("defer_push_flg", O_PUSH);
        step(); check_outs("defer_vector", O_VEC);
        step(); check_outs("defer_isr", O_ISR);
        irq = 1'b0; rti_ex = 1'b1;
        step(); check_outs("final_rti_idle", O_IDLE);
        rti_ex = 1'b0;
        step(); step();
        check_outs("final_idle_stays", O_IDLE);
        check("push_queue_drained", exp_push.size(), 32'd0);
        check("vector_queue_drained", exp_vec.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
